// File: rtl/pdp_fifo_ctrl.sv
// Stream FIFO over an external pseudo-dual-port RAM with a 2-entry output skid; empty-to-output latency is 2 edges.
// Backpressure: s_ready falls only when the RAM holds D words; RAM reads stall while skid + in-flight read would exceed 2.
module pdp_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH+1:0] level,
  output logic                  ram_ena,
  output logic                  ram_wea,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [DATA_WIDTH-1:0] ram_dia,
  output logic                  ram_enb,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  input  logic [DATA_WIDTH-1:0] ram_dob
);

  localparam logic [ADDR_WIDTH:0]   DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   OCC_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = OCC_ONE[ADDR_WIDTH-1:0];

  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [ADDR_WIDTH-1:0] r_rptr;
  logic [ADDR_WIDTH:0]   r_occ;
  logic                  r_rd_pend;
  logic [1:0]            r_skid_cnt;
  logic [DATA_WIDTH-1:0] r_skid0;
  logic [DATA_WIDTH-1:0] r_skid1;

  logic                  w_wr;
  logic                  w_rd;
  logic                  w_pop;
  logic [2:0]            w_inflight;
  logic [1:0]            w_cnt_ap;
  logic [1:0]            w_cnt_nxt;
  logic [DATA_WIDTH-1:0] w_skid0_nxt;
  logic [DATA_WIDTH-1:0] w_skid1_nxt;
  logic [ADDR_WIDTH:0]   w_occ_nxt;

  assign s_ready    = (r_occ != DEPTH) & ~rst & ~flush;
  assign w_wr       = s_valid & s_ready;
  assign m_valid    = (r_skid_cnt != 2'd0);
  assign m_data     = r_skid0;
  assign w_pop      = m_valid & m_ready;
  assign w_inflight = {1'b0, r_skid_cnt} + {2'b00, r_rd_pend};

  // A read is only issued if its data is guaranteed a skid slot when it lands.
  assign w_rd = (r_occ != '0) & ~flush & ~rst &
                ((w_inflight - {2'b00, w_pop}) < 3'd2);

  assign ram_ena   = w_wr;
  assign ram_wea   = w_wr;
  assign ram_addra = r_wptr;
  assign ram_dia   = s_data;
  assign ram_enb   = w_rd;
  assign ram_addrb = r_rptr;

  assign level = {1'b0, r_occ}
               + {{(ADDR_WIDTH+1){1'b0}}, r_rd_pend}
               + {{ADDR_WIDTH{1'b0}}, r_skid_cnt};

  assign w_cnt_ap = r_skid_cnt - {1'b0, w_pop};

  always_comb begin
    w_skid0_nxt = r_skid0;
    w_skid1_nxt = r_skid1;
    w_cnt_nxt   = w_cnt_ap;
    if (w_pop) begin
      w_skid0_nxt = r_skid1;
    end
    if (r_rd_pend) begin
      if (w_cnt_ap == 2'd0) begin
        w_skid0_nxt = ram_dob;
      end else begin
        w_skid1_nxt = ram_dob;
      end
      w_cnt_nxt = w_cnt_ap + 2'd1;
    end
  end

  always_comb begin
    w_occ_nxt = r_occ;
    if (w_wr && !w_rd) begin
      w_occ_nxt = r_occ + OCC_ONE;
    end else if (!w_wr && w_rd) begin
      w_occ_nxt = r_occ - OCC_ONE;
    end
  end

  // Clearing r_rd_pend is what discards a RAM word still in flight.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_occ      <= '0;
      r_rd_pend  <= 1'b0;
      r_skid_cnt <= 2'd0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_rd) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      r_occ      <= w_occ_nxt;
      r_rd_pend  <= w_rd;
      r_skid_cnt <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    r_skid0 <= w_skid0_nxt;
    r_skid1 <= w_skid1_nxt;
  end

endmodule

// File: tb/tb_pdp_fifo_ctrl.sv
// Bench for pdp_fifo_ctrl with D=4: vector table, streaming, random stalls, flush and reset aborts.
module tb_pdp_fifo_ctrl;

  localparam int DW = 8;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [AW+1:0] level;
  logic          ram_ena;
  logic          ram_wea;
  logic [AW-1:0] ram_addra;
  logic [DW-1:0] ram_dia;
  logic          ram_enb;
  logic [AW-1:0] ram_addrb;
  logic [DW-1:0] ram_dob;

  pdp_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .level(level),
    .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dia(ram_dia),
    .ram_enb(ram_enb), .ram_addrb(ram_addrb), .ram_dob(ram_dob)
  );

  always #5 clk = ~clk;

  // External RAM: registered read port.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_ena && ram_wea) mem[ram_addra] <= ram_dia;
    if (ram_enb) ram_dob <= mem[ram_addrb];
  end

  int            total = 0;
  int            bad   = 0;
  int            n_pop = 0;
  logic [DW-1:0] sb [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: samples mid-cycle, handshakes complete at the following rising edge.
  initial begin : monitor
    logic          held_vld;
    logic [DW-1:0] held_dat;
    logic [DW-1:0] exp_w;
    held_vld = 1'b0;
    held_dat = '0;
    forever begin
      @(negedge clk);
      if (rst || flush) begin
        sb.delete();
        held_vld = 1'b0;
      end else begin
        if (held_vld) begin
          check("stall_valid", m_valid, 1);
          check("stall_data", m_data, held_dat);
        end
        if (m_valid && m_ready) begin
          n_pop++;
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL pop_unexpected: got %0h expected no word", m_data);
          end else begin
            exp_w = sb.pop_front();
            check("pop_order", m_data, exp_w);
          end
        end
        held_vld = m_valid && !m_ready;
        held_dat = m_data;
        if (s_valid && s_ready) sb.push_back(s_data);
      end
    end
  end

  typedef struct {
    logic          fl;
    logic          sv;
    logic [DW-1:0] sd;
    logic          mr;
    logic          e_srdy;
    logic          e_mvld;
    logic [DW-1:0] e_mdat;
    logic [AW+1:0] e_lvl;
  } vec_t;

  vec_t vt [13];

  task automatic drain(input int budget, input bit rand_rdy);
    int k;
    k = 0;
    s_valid = 1'b0;
    while ((level != 0 || m_valid) && k < budget) begin
      m_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      k++;
    end
    check("drain_level", level, 0);
    check("drain_sb_empty", sb.size(), 0);
  endtask

  task automatic abort_seq(input bit use_rst);
    bit got;
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 8'hA1; tick();
    s_data = 8'hA2; tick();
    s_data = 8'hA3; tick();
    check("abort_pre_level", level, 3);
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    s_data = 8'h55;
    #1;
    check("abort_ram_ena", ram_ena, 0);
    check("abort_ram_enb", ram_enb, 0);
    check("abort_s_ready", s_ready, 0);
    tick();
    rst = 1'b0; flush = 1'b0; s_valid = 1'b0;
    #1;
    check("abort_level", level, 0);
    check("abort_m_valid", m_valid, 0);
    check("abort_s_ready_after", s_ready, 1);
    s_valid = 1'b1; s_data = 8'h7E; m_ready = 1'b1;
    tick();
    s_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      if (m_valid) begin
        got = 1'b1;
        check("abort_next_word", m_data, 8'h7E);
      end else begin
        tick();
      end
    end
    check("abort_word_seen", got, 1);
    tick();
    check("abort_final_level", level, 0);
    check("abort_sb_empty", sb.size(), 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n0;
    int idx;
    int cyc;
    logic acc;

    //          fl   sv   sd     mr    srdy mvld mdat   lvl
    vt[0]  = '{1'b0,1'b1,8'hA5,1'b1, 1'b1,1'b0,8'h00,4'd0};
    vt[1]  = '{1'b0,1'b0,8'h00,1'b1, 1'b1,1'b0,8'h00,4'd1};
    vt[2]  = '{1'b0,1'b0,8'h00,1'b1, 1'b1,1'b0,8'h00,4'd1};
    vt[3]  = '{1'b0,1'b0,8'h00,1'b1, 1'b1,1'b1,8'hA5,4'd1};
    vt[4]  = '{1'b0,1'b0,8'h00,1'b0, 1'b1,1'b0,8'h00,4'd0};
    vt[5]  = '{1'b0,1'b1,8'h01,1'b0, 1'b1,1'b0,8'h00,4'd0};
    vt[6]  = '{1'b0,1'b1,8'h02,1'b0, 1'b1,1'b0,8'h00,4'd1};
    vt[7]  = '{1'b0,1'b1,8'h03,1'b0, 1'b1,1'b0,8'h00,4'd2};
    vt[8]  = '{1'b0,1'b1,8'h04,1'b0, 1'b1,1'b1,8'h01,4'd3};
    vt[9]  = '{1'b0,1'b1,8'h05,1'b0, 1'b1,1'b1,8'h01,4'd4};
    vt[10] = '{1'b0,1'b1,8'h06,1'b0, 1'b1,1'b1,8'h01,4'd5};
    vt[11] = '{1'b0,1'b1,8'h07,1'b0, 1'b0,1'b1,8'h01,4'd6};
    vt[12] = '{1'b0,1'b0,8'h00,1'b1, 1'b0,1'b1,8'h01,4'd6};

    rst = 1'b1; flush = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    tick();
    tick();
    check("rst_s_ready", s_ready, 0);
    rst = 1'b0;
    #1;
    check("reset_m_valid", m_valid, 0);
    check("reset_level", level, 0);
    check("reset_s_ready", s_ready, 1);
    check("reset_ram_ena", ram_ena, 0);
    check("reset_ram_enb", ram_enb, 0);

    // Single word latency, then fill to D+2 with the consumer stalled.
    for (int i = 0; i < 13; i++) begin
      flush = vt[i].fl; s_valid = vt[i].sv; s_data = vt[i].sd; m_ready = vt[i].mr;
      #1;
      check($sformatf("vec%0d_s_ready", i), s_ready, vt[i].e_srdy);
      check($sformatf("vec%0d_m_valid", i), m_valid, vt[i].e_mvld);
      check($sformatf("vec%0d_level", i), level, vt[i].e_lvl);
      if (vt[i].e_mvld) check($sformatf("vec%0d_m_data", i), m_data, vt[i].e_mdat);
      tick();
    end

    // From full: one read frees a slot, then one-in/one-out per cycle.
    check("full_s_ready_back", s_ready, 1);
    check("full_level_after_read", level, 5);
    n0 = n_pop;
    for (int i = 0; i < 20; i++) begin
      s_valid = 1'b1; s_data = 8'(8'h07 + i); m_ready = 1'b1;
      #1;
      check("stream_s_ready", s_ready, 1);
      tick();
    end
    check("stream_throughput", n_pop - n0, 20);
    drain(50, 1'b0);

    // Random consumer stalls.
    n0 = n_pop; idx = 0; cyc = 0;
    while (idx < 20 && cyc < 400) begin
      s_valid = 1'b1; s_data = 8'(8'h10 + idx); m_ready = 1'($urandom_range(0, 1));
      #1;
      acc = s_ready;
      tick();
      if (acc) idx++;
      cyc++;
    end
    check("rand_accepted", idx, 20);
    drain(400, 1'b1);
    check("rand_pop_count", n_pop - n0, 20);

    abort_seq(1'b0);
    abort_seq(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
